// File: rtl/axi4lite_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_regfile_if
// Description : AXI4-Lite AW/W/B/AR/R channel bundle between the upstream
//               Wishbone bridge (master) and the register file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4lite_regfile_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic            s_axi_awvalid;
  logic            s_axi_awready;
  logic [AW-1:0]   s_axi_awaddr;
  logic [2:0]      s_axi_awprot;
  logic            s_axi_wvalid;
  logic            s_axi_wready;
  logic [DW-1:0]   s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic            s_axi_bvalid;
  logic            s_axi_bready;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_arvalid;
  logic            s_axi_arready;
  logic [AW-1:0]   s_axi_araddr;
  logic [2:0]      s_axi_arprot;
  logic            s_axi_rvalid;
  logic            s_axi_rready;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    output s_axi_bready,
    output s_axi_arvalid, s_axi_araddr, s_axi_arprot,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bvalid, s_axi_bresp,
    input  s_axi_arready,
    input  s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
    input  s_axi_bready,
    input  s_axi_arvalid, s_axi_araddr, s_axi_arprot,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bvalid, s_axi_bresp,
    output s_axi_arready,
    output s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );
endinterface
`default_nettype wire

// File: rtl/axi4lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_regfile
// Description : AXI4-Lite slave register bank. Independent write and read
//               FSMs, byte strobes, SLVERR on writes to the read-only ID
//               register, DECERR outside the bank. Contents exported flat.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_regfile #(
  parameter int          DW       = 32,
  parameter int          AW       = 32,
  parameter int          NREGS    = 16,
  parameter logic [31:0] ID_VALUE = 32'h5742_4158
) (
  input  wire logic              wb_clk_i,
  input  wire logic              wb_rst_ni,
  axi4lite_regfile_if.slave      axi,
  output logic [NREGS*DW-1:0]    regs_o
);

  localparam int         c_IW     = $clog2(NREGS);
  localparam int         c_NB     = DW / 8;
  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_SLVERR = 2'b10;
  localparam logic [1:0] c_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return (a[AW-1:c_IW+2] == '0);
  endfunction

  function automatic logic [c_IW-1:0] addr_index(input logic [AW-1:0] a);
    return a[c_IW+1:2];
  endfunction

  // State
  w_state_t         r_w_state;
  r_state_t         r_r_state;
  logic             r_rst_sync;
  logic             r_awready;
  logic             r_wready;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic [AW-1:0]    r_awaddr;
  logic [DW-1:0]    r_wdata;
  logic [c_NB-1:0]  r_wstrb;
  logic             r_arready;
  logic             r_rvalid;
  logic [1:0]       r_rresp;
  logic [DW-1:0]    r_rdata;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;
  logic             w_commit;
  logic [AW-1:0]    w_commit_addr;
  logic [DW-1:0]    w_commit_data;
  logic [c_NB-1:0]  w_commit_strb;
  logic [1:0]       w_commit_resp;
  logic [c_IW-1:0]  w_commit_idx;
  logic             w_commit_ok;
  logic [DW-1:0]    w_regs [NREGS];
  logic             w_unused;

  assign w_aw_hs = axi.s_axi_awvalid & r_awready;
  assign w_w_hs  = axi.s_axi_wvalid  & r_wready;
  assign w_ar_hs = axi.s_axi_arvalid & r_arready;

  // Protection bits and byte-lane address bits carry no meaning here.
  assign w_unused = ^{axi.s_axi_awprot, axi.s_axi_arprot,
                      axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0], r_awaddr[1:0]};

  // First reset-release stage; the registered ready flops form the second.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_rst_sync <= 1'b0;
    else            r_rst_sync <= 1'b1;
  end

  // Select address/data for the write that completes this cycle, if any.
  always_comb begin
    w_commit      = 1'b0;
    w_commit_addr = axi.s_axi_awaddr;
    w_commit_data = axi.s_axi_wdata;
    w_commit_strb = axi.s_axi_wstrb;
    case (r_w_state)
      W_IDLE:    w_commit = w_aw_hs & w_w_hs;
      W_HAVE_AW: begin
        w_commit      = w_w_hs;
        w_commit_addr = r_awaddr;
      end
      W_HAVE_W:  begin
        w_commit      = w_aw_hs;
        w_commit_data = r_wdata;
        w_commit_strb = r_wstrb;
      end
      default:   w_commit = 1'b0;
    endcase
  end

  assign w_commit_idx  = addr_index(w_commit_addr);
  assign w_commit_resp = !addr_in_range(w_commit_addr) ? c_DECERR :
                         (w_commit_idx == '0)          ? c_SLVERR : c_OKAY;
  assign w_commit_ok   = w_commit & (w_commit_resp == c_OKAY);

  // Write FSM: collects AW and W in either order, then holds B until accepted.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_w_state <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_aw_hs && w_w_hs) begin
            r_w_state <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_commit_resp;
          end else if (w_aw_hs) begin
            r_w_state <= W_HAVE_AW;
            r_awaddr  <= axi.s_axi_awaddr;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
          end else if (w_w_hs) begin
            r_w_state <= W_HAVE_W;
            r_wdata   <= axi.s_axi_wdata;
            r_wstrb   <= axi.s_axi_wstrb;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= r_rst_sync;
            r_wready  <= r_rst_sync;
          end
        end
        W_HAVE_AW: begin
          if (w_w_hs) begin
            r_w_state <= W_RESP;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_commit_resp;
          end
        end
        W_HAVE_W: begin
          if (w_aw_hs) begin
            r_w_state <= W_RESP;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_commit_resp;
          end
        end
        W_RESP: begin
          if (axi.s_axi_bready) begin
            r_w_state <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= r_rst_sync;
            r_wready  <= r_rst_sync;
          end
        end
        default: begin
          r_w_state <= W_IDLE;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Register bank: slot 0 is the constant ID, others are byte-writable.
  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    if (i == 0) begin : g_id
      assign w_regs[i] = ID_VALUE;
    end else begin : g_rw
      logic [DW-1:0] r_reg;
      // Byte-masked update when a successful write targets this slot.
      always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
          r_reg <= '0;
        end else if (w_commit_ok && (w_commit_idx == c_IW'(i))) begin
          for (int b = 0; b < c_NB; b++) begin
            if (w_commit_strb[b]) r_reg[b*8 +: 8] <= w_commit_data[b*8 +: 8];
          end
        end
      end
      assign w_regs[i] = r_reg;
    end
    assign regs_o[i*DW +: DW] = w_regs[i];
  end

  // Read FSM: samples the bank on AR (pre-write value on a same-edge commit).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= c_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_r_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_r_state <= R_RESP;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            if (addr_in_range(axi.s_axi_araddr)) begin
              r_rdata <= w_regs[addr_index(axi.s_axi_araddr)];
              r_rresp <= c_OKAY;
            end else begin
              r_rdata <= '0;
              r_rresp <= c_DECERR;
            end
          end else begin
            r_arready <= r_rst_sync;
          end
        end
        R_RESP: begin
          if (axi.s_axi_rready) begin
            r_r_state <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= r_rst_sync;
          end
        end
        default: begin
          r_r_state <= R_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign axi.s_axi_awready = r_awready;
  assign axi.s_axi_wready  = r_wready;
  assign axi.s_axi_bvalid  = r_bvalid;
  assign axi.s_axi_bresp   = r_bresp;
  assign axi.s_axi_arready = r_arready;
  assign axi.s_axi_rvalid  = r_rvalid;
  assign axi.s_axi_rdata   = r_rdata;
  assign axi.s_axi_rresp   = r_rresp;

endmodule
`default_nettype wire
